// File: rtl/rocc_ctrl_if.sv
// rtl/rocc_ctrl_if.sv - RoCC command/response types and the core-side RoCC bus interface
package rocc_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
    } rocc_cmd_t;

    typedef struct packed {
        logic [63:0] resp_data;
        logic [4:0]  resp_rd;
    } rocc_resp_t;

endpackage

interface rocc_ctrl_if;
    import rocc_pkg::*;

    logic       issue_valid_i;
    logic       issue_ready_o;
    rocc_cmd_t  issue_cmd_i;
    logic [4:0] issue_rd_i;
    logic       issue_xd_i;

    rocc_cmd_t  rocc_cmd_o;
    logic       rocc_cmd_valid_o;
    logic       rocc_cmd_ready_i;

    rocc_resp_t rocc_resp_i;
    logic       rocc_resp_valid_i;
    logic       rocc_resp_ready_o;

    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_o;
    logic        wb_ack_i;

    logic [31:0] rd_pending_o;
    logic        busy_o;
    logic        spurious_o;

    // Controller side
    modport slave (
        input  issue_valid_i, issue_cmd_i, issue_rd_i, issue_xd_i,
        input  rocc_cmd_ready_i, rocc_resp_i, rocc_resp_valid_i, wb_ack_i,
        output issue_ready_o, rocc_cmd_o, rocc_cmd_valid_o, rocc_resp_ready_o,
        output wb_valid_o, wb_rd_o, wb_data_o, rd_pending_o, busy_o, spurious_o
    );

    // Issue stage / accelerator / writeback side
    modport master (
        output issue_valid_i, issue_cmd_i, issue_rd_i, issue_xd_i,
        output rocc_cmd_ready_i, rocc_resp_i, rocc_resp_valid_i, wb_ack_i,
        input  issue_ready_o, rocc_cmd_o, rocc_cmd_valid_o, rocc_resp_ready_o,
        input  wb_valid_o, wb_rd_o, wb_data_o, rd_pending_o, busy_o, spurious_o
    );

endinterface

// File: rtl/rocc_ctrl.sv
// rtl/rocc_ctrl.sv - core-side RoCC initiator with rd tracking and writeback holding register
module rocc_ctrl
    import rocc_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    rocc_ctrl_if.slave bus
);

    rocc_cmd_t   cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [31:0] pending_q, pending_d;
    logic [3:0]  count_q, count_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic        spurious_q, spurious_d;
    logic        busy_q, busy_d;

    logic issue_ready;
    logic issue_fire;
    logic resp_ready;
    logic resp_fire;
    logic resp_hit;
    logic at_limit;

    // Handshake gating uses registered tracking state only; nothing is accepted while in reset
    always_comb begin
        at_limit    = (count_q == 4'(MAX_OUTSTANDING));
        issue_ready = rst_ni && (!cmd_valid_q || bus.rocc_cmd_ready_i)
                      && !(bus.issue_xd_i && (pending_q[bus.issue_rd_i] || at_limit));
        issue_fire  = bus.issue_valid_i && issue_ready;
        resp_ready  = rst_ni && (!wb_valid_q || bus.wb_ack_i);
        resp_fire   = bus.rocc_resp_valid_i && resp_ready;
        resp_hit    = pending_q[bus.rocc_resp_i.resp_rd];
    end

    // Next-state for command register, pending bitmap, count, writeback register and status
    always_comb begin
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        pending_d   = pending_q;
        count_d     = count_q;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        spurious_d  = 1'b0;

        if (issue_fire) begin
            cmd_d       = bus.issue_cmd_i;
            cmd_valid_d = 1'b1;
        end else if (bus.rocc_cmd_ready_i) begin
            cmd_valid_d = 1'b0;
        end

        if (bus.wb_ack_i) begin
            wb_valid_d = 1'b0;
        end

        // A response for rd=x0 still retires its pending entry but never writes back
        if (resp_fire) begin
            if (resp_hit) begin
                pending_d[bus.rocc_resp_i.resp_rd] = 1'b0;
                count_d = count_d - 4'd1;
                if (bus.rocc_resp_i.resp_rd != 5'd0) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = bus.rocc_resp_i.resp_rd;
                    wb_data_d  = bus.rocc_resp_i.resp_data;
                end
            end else begin
                spurious_d = 1'b1;
            end
        end

        // Issue gating guarantees the rd being set is not the one being cleared
        if (issue_fire && bus.issue_xd_i) begin
            pending_d[bus.issue_rd_i] = 1'b1;
            count_d = count_d + 4'd1;
        end

        busy_d = cmd_valid_d || (count_d != 4'd0) || wb_valid_d;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            pending_q   <= '0;
            count_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            spurious_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            pending_q   <= pending_d;
            count_q     <= count_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            spurious_q  <= spurious_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.issue_ready_o     = issue_ready;
    assign bus.rocc_cmd_o        = cmd_q;
    assign bus.rocc_cmd_valid_o  = cmd_valid_q;
    assign bus.rocc_resp_ready_o = resp_ready;
    assign bus.wb_valid_o        = wb_valid_q;
    assign bus.wb_rd_o           = wb_rd_q;
    assign bus.wb_data_o         = wb_data_q;
    assign bus.rd_pending_o      = pending_q;
    assign bus.busy_o            = busy_q;
    assign bus.spurious_o        = spurious_q;

endmodule
